sad_row_engine: RTL and testbench

//  Motion-estimation SAD stage, directly downstream of the search-window memory.
//  - Consumes one search-window row per beat: 19 reference pixels, as returned by the memory's 19-pixel row read.
//  - Pairs it with the 16-pixel current-block row.
//  - Accumulates SAD for the 4 horizontal candidate offsets (0..3) over 16 rows.
//  - Reports the minimum SAD and its offset index to the MV controller.

---
 rtl/me_pkg.sv | 27 ++
 rtl/sad_row_calc.sv | 23 ++
 rtl/sad_row_engine.sv | 134 +++++++++++++
 tb/tb_sad_row_engine.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// Shared motion-estimation constants, FSM state encoding and pixel helper.
package me_pkg;

  localparam int unsigned PIX_W     = 8;                 // pixel width, unsigned
  localparam int unsigned BLK       = 16;                // block width = rows per block
  localparam int unsigned NCAND     = 4;                 // horizontal candidate offsets
  localparam int unsigned REF_W     = BLK + NCAND - 1;   // reference pixels per row (19)
  localparam int unsigned SAD_ROW_W = 12;                // one row SAD, max 16*255 = 4080
  localparam int unsigned SAD_ACC_W = 16;                // block SAD, max 16*4080 = 65280
  localparam int unsigned CAND_W    = 2;                 // candidate index width
  localparam int unsigned CNT_W     = 4;                 // row counter width

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACCUM = 3'd1,
    ST_DRAIN = 3'd2,
    ST_CMP   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Absolute difference of two unsigned pixels; always fits in PIX_W bits.
  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/sad_row_calc.sv
// Combinational SAD of one 16-pixel row pair for a single candidate offset.
// Ports:
//   i_ref    16 reference pixels already shifted to the candidate offset
//   i_cur    16 current-block pixels
//   o_sad_c  sum of per-pixel absolute differences (combinational)
module sad_row_calc
  import me_pkg::*;
(
  input  logic [BLK*PIX_W-1:0] i_ref,
  input  logic [BLK*PIX_W-1:0] i_cur,
  output logic [SAD_ROW_W-1:0] o_sad_c
);

  // Adder tree expressed as a loop; synthesis balances it.
  always_comb begin
    o_sad_c = '0;
    for (int j = 0; j < BLK; j++) begin
      o_sad_c = o_sad_c + SAD_ROW_W'(abs_diff(i_ref[j*PIX_W +: PIX_W],
                                              i_cur[j*PIX_W +: PIX_W]));
    end
  end

endmodule

// File: rtl/sad_row_engine.sv
// Motion-estimation SAD stage: accumulates row SADs for 4 horizontal
// candidate offsets over a 16-row block, then reports the minimum.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begin a block evaluation (honoured in IDLE/DONE)
//   row_valid           ref_row/cur_row carry a valid row
//   ref_row, cur_row    19 reference pixels, 16 current pixels
//   row_ready           engine accepts a row this cycle
//   busy                evaluation in progress
//   done                one-cycle pulse, best_sad/best_idx valid
//   best_sad, best_idx  minimum block SAD and its candidate offset
module sad_row_engine
  import me_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   row_valid,
  input  logic [REF_W*PIX_W-1:0] ref_row,
  input  logic [BLK*PIX_W-1:0]   cur_row,
  output logic                   row_ready,
  output logic                   busy,
  output logic                   done,
  output logic [SAD_ACC_W-1:0]   best_sad,
  output logic [CAND_W-1:0]      best_idx
);

  state_e               r_state;
  logic [CNT_W-1:0]     r_row_cnt;
  logic [SAD_ROW_W-1:0] r_rsad [NCAND];
  logic                 r_s1_valid;
  logic [SAD_ACC_W-1:0] r_acc  [NCAND];
  logic [CAND_W-1:0]    r_cand_idx;
  logic [SAD_ACC_W-1:0] r_run_sad;
  logic [CAND_W-1:0]    r_run_idx;

  logic [SAD_ROW_W-1:0] w_rsad [NCAND];
  logic                 w_accept;
  logic [SAD_ACC_W-1:0] w_cand_sad;
  logic                 w_take;
  logic [SAD_ACC_W-1:0] w_new_sad;
  logic [CAND_W-1:0]    w_new_idx;

  // Candidate c sees reference pixels c..c+15.
  for (genvar c = 0; c < NCAND; c++) begin : g_cand
    sad_row_calc u_calc (
      .i_ref   (ref_row[c*PIX_W +: BLK*PIX_W]),
      .i_cur   (cur_row),
      .o_sad_c (w_rsad[c])
    );
  end

  assign w_accept = row_valid & row_ready;

  // Running minimum; candidate 0 always loads, later ones need strictly smaller.
  assign w_cand_sad = r_acc[r_cand_idx];
  assign w_take     = (r_cand_idx == '0) || (w_cand_sad < r_run_sad);
  assign w_new_sad  = w_take ? w_cand_sad : r_run_sad;
  assign w_new_idx  = w_take ? r_cand_idx : r_run_idx;

  // FSM, pipeline stages and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_row_cnt  <= '0;
      r_s1_valid <= 1'b0;
      r_cand_idx <= '0;
      r_run_sad  <= '0;
      r_run_idx  <= '0;
      for (int c = 0; c < NCAND; c++) begin
        r_rsad[c] <= '0;
        r_acc[c]  <= '0;
      end
      row_ready  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      best_sad   <= '0;
      best_idx   <= '0;
    end else begin
      done       <= 1'b0;
      r_s1_valid <= w_accept;
      if (w_accept) begin
        for (int c = 0; c < NCAND; c++) r_rsad[c] <= w_rsad[c];
      end
      if (r_s1_valid) begin
        for (int c = 0; c < NCAND; c++) r_acc[c] <= r_acc[c] + SAD_ACC_W'(r_rsad[c]);
      end

      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            for (int c = 0; c < NCAND; c++) r_acc[c] <= '0;
            r_row_cnt <= '0;
            r_state   <= ST_ACCUM;
            row_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_ACCUM: begin
          if (w_accept) begin
            r_row_cnt <= r_row_cnt + CNT_W'(1);
            if (r_row_cnt == CNT_W'(BLK - 1)) begin
              r_state   <= ST_DRAIN;
              row_ready <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          // Last row's stage-2 add lands on this edge.
          r_state    <= ST_CMP;
          r_cand_idx <= '0;
        end
        ST_CMP: begin
          r_run_sad  <= w_new_sad;
          r_run_idx  <= w_new_idx;
          r_cand_idx <= r_cand_idx + CAND_W'(1);
          if (r_cand_idx == CAND_W'(NCAND - 1)) begin
            best_sad <= w_new_sad;
            best_idx <= w_new_idx;
            done     <= 1'b1;
            busy     <= 1'b0;
            r_state  <= ST_DONE;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          row_ready <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sad_row_engine.sv
// Directed bench for sad_row_engine: table of whole-block vectors plus
// hand-written reset and protocol sequences.
module tb_sad_row_engine;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         row_valid;
  logic [151:0] ref_row;
  logic [127:0] cur_row;
  logic         row_ready;
  logic         busy;
  logic         done;
  logic [15:0]  best_sad;
  logic [1:0]   best_idx;

  int total;
  int bad;

  sad_row_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .row_valid (row_valid),
    .ref_row   (ref_row),
    .cur_row   (cur_row),
    .row_ready (row_ready),
    .busy      (busy),
    .done      (done),
    .best_sad  (best_sad),
    .best_idx  (best_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [151:0] ref_r;
    logic [127:0] cur_r;
    bit           gaps;
    bit           start_mid;
    logic [15:0]  exp_sad;
    logic [1:0]   exp_idx;
    int           exp_lat;   // 0 = latency not checked
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Runs one block with the same row repeated; checks result, latency and handshake.
  task automatic run_vec(input int id, input vec_t v);
    int  acc_cnt;
    int  done_k;
    int  proto_err;
    bit  pv;
    bit  pr;
    ref_row = v.ref_r;
    cur_row = v.cur_r;
    @(negedge clk);
    start     = 1'b1;
    row_valid = 1'b0;
    acc_cnt   = 0;
    done_k    = 0;
    proto_err = 0;
    pv        = 1'b0;
    pr        = 1'b0;
    for (int k = 1; k <= 400 && done_k == 0; k++) begin
      @(negedge clk);
      if (pv && pr) acc_cnt++;
      start = v.start_mid && (k == 6);
      if (row_ready !== (acc_cnt < 16)) proto_err++;
      if (done === 1'b1) begin
        done_k = k;
        if (busy !== 1'b0) proto_err++;
      end else if (busy !== 1'b1) begin
        proto_err++;
      end
      pr = row_ready;
      pv = v.gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      row_valid = pv;
    end
    chk($sformatf("vec%0d done_seen", id), 32'(done_k != 0), 32'd1);
    chk($sformatf("vec%0d rows_accepted", id), 32'(acc_cnt), 32'd16);
    chk($sformatf("vec%0d best_sad", id), 32'(best_sad), 32'(v.exp_sad));
    chk($sformatf("vec%0d best_idx", id), 32'(best_idx), 32'(v.exp_idx));
    chk($sformatf("vec%0d handshake_errs", id), 32'(proto_err), 32'd0);
    if (v.exp_lat != 0) chk($sformatf("vec%0d latency", id), 32'(done_k), 32'(v.exp_lat));
    // done is a single pulse and results hold in DONE, even with row_valid high.
    @(negedge clk);
    chk($sformatf("vec%0d done_pulse", id), 32'(done), 32'd0);
    chk($sformatf("vec%0d hold_sad", id), 32'(best_sad), 32'(v.exp_sad));
    chk($sformatf("vec%0d ready_in_done", id), 32'(row_ready), 32'd0);
    row_valid = 1'b0;
  endtask

  initial begin
    logic [151:0] rr;
    logic [127:0] cc;
    int           cnt;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    row_valid = 1'b0;
    ref_row = '0;
    cur_row = '0;

    // 0: identical rows, all-candidate tie -> index 0
    for (int p = 0; p < 19; p++) rr[p*8 +: 8] = 8'h40;
    for (int p = 0; p < 16; p++) cc[p*8 +: 8] = 8'h40;
    tbl[0] = '{rr, cc, 1'b0, 1'b0, 16'd0, 2'd0, 22};
    // 1: ramp, acc[c] = 1920 + 256c
    for (int p = 0; p < 19; p++) rr[p*8 +: 8] = 8'(p);
    for (int p = 0; p < 16; p++) cc[p*8 +: 8] = 8'd0;
    tbl[1] = '{rr, cc, 1'b0, 1'b0, 16'd1920, 2'd0, 22};
    // 2: exact match at offset 2
    for (int p = 0; p < 19; p++) rr[p*8 +: 8] = (p >= 2 && p <= 17) ? 8'd10 : 8'd255;
    for (int p = 0; p < 16; p++) cc[p*8 +: 8] = 8'd10;
    tbl[2] = '{rr, cc, 1'b0, 1'b0, 16'd0, 2'd2, 22};
    // 3: worst case 16*16*255
    for (int p = 0; p < 19; p++) rr[p*8 +: 8] = 8'd255;
    for (int p = 0; p < 16; p++) cc[p*8 +: 8] = 8'd0;
    tbl[3] = '{rr, cc, 1'b0, 1'b0, 16'd65280, 2'd0, 22};
    // 4: descending ramp, acc[c] = 16*(168-16c), best at offset 3
    for (int p = 0; p < 19; p++) rr[p*8 +: 8] = 8'(18 - p);
    for (int p = 0; p < 16; p++) cc[p*8 +: 8] = 8'd0;
    tbl[4] = '{rr, cc, 1'b0, 1'b0, 16'd1920, 2'd3, 22};
    // 5: tie between offsets 1 and 2 -> lower index wins
    for (int p = 0; p < 19; p++) rr[p*8 +: 8] = (p >= 1 && p <= 17) ? 8'd10 : 8'd255;
    for (int p = 0; p < 16; p++) cc[p*8 +: 8] = 8'd10;
    tbl[5] = '{rr, cc, 1'b0, 1'b0, 16'd0, 2'd1, 22};
    // 6: ramp with random row_valid gaps and a start pulse during ACCUM
    for (int p = 0; p < 19; p++) rr[p*8 +: 8] = 8'(p);
    for (int p = 0; p < 16; p++) cc[p*8 +: 8] = 8'd0;
    tbl[6] = '{rr, cc, 1'b1, 1'b1, 16'd1920, 2'd0, 0};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst row_ready", 32'(row_ready), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst best_sad", 32'(best_sad), 32'd0);
    chk("rst best_idx", 32'(best_idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // row_valid in IDLE is ignored
    row_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle row_ready", 32'(row_ready), 32'd0);
    chk("idle busy", 32'(busy), 32'd0);
    row_valid = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(i, tbl[i]);

    // Reset during accumulation after row 7 aborts with no done.
    ref_row = tbl[1].ref_r;
    cur_row = tbl[1].cur_r;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    row_valid = 1'b1;
    repeat (8) @(negedge clk);
    chk("midop busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midop row_ready", 32'(row_ready), 32'd0);
    chk("midop busy", 32'(busy), 32'd0);
    chk("midop best_sad", 32'(best_sad), 32'd0);
    chk("midop best_idx", 32'(best_idx), 32'd0);
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done !== 1'b0) cnt++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done !== 1'b0) cnt++;
    end
    chk("midop no_done", 32'(cnt), 32'd0);
    chk("midop idle_after", 32'(busy), 32'd0);
    row_valid = 1'b0;
    run_vec(7, tbl[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
